mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
Sequencer for the EX-stage iterative multiplier serving RV32M MUL/MULH/MULHSU/MULHU.
- Captures operands when a multiply instruction enters EX, runs a 32-step shift-add, applies sign correction, and raises a one-cycle mul_finish.
- The hazard unit holds IF/ID/PC while a multiply sits in ID/EX and mul_finish is low.
- Sits beside the ALU; mul_result feeds the EX/MEM result mux.

Parameters:
XLEN, 32, operand/result width
ZERO_SKIP, 1, 1 = either operand zero bypasses iteration

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-low reset (rst==0 at a rising edge resets)
mul_start  input  1  ID/EX holds a valid multiply instruction
mul_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
flush  input  1  ID/EX instruction killed (branch/jump redirect)
rs1_data  input  XLEN  forwarded rs1 operand
rs2_data  input  XLEN  forwarded rs2 operand
mul_busy  output  1  state != IDLE
mul_finish  output  1  one-cycle pulse, mul_result valid
mul_result  output  XLEN  registered result, held until next completion

Behaviour:
- Reset: state=IDLE; mul_busy=0, mul_finish=0, mul_result=0; count, accumulator and operand registers cleared. Reset mid-operation aborts with no finish pulse.
- States IDLE, BUSY, DONE; one transition per clock.
- IDLE, mul_start=1, flush=0:
  - Latch op, the sign flag, |rs1| and |rs2|.
  - Signedness: MUL and MULH treat both operands as signed; MULHSU treats rs1 signed, rs2 unsigned; MULHU treats both unsigned.
  - Sign flag = signed rs1 negative XOR signed rs2 negative.
  - Magnitudes are XLEN-bit unsigned, so 0x80000000 yields 2^31.
  - Next state is BUSY, count=0.
  - If ZERO_SKIP and either operand is 0: next state is DONE with mul_result=0.
- IDLE with flush=1: mul_start is ignored.
- BUSY:
  - Each cycle: if multiplier LSB is 1, acc_hi += multiplicand (XLEN+1-bit add, carry kept); then {carry,acc_hi,acc_lo} shifts right 1; count++.
  - After iteration 32 (count==31 at the edge), next state is DONE.
  - On that edge, mul_result loads the selected half of the 2*XLEN product. If the sign flag is set, the product is two's-complement negated first.
  - Half selection: MUL takes [31:0]; MULH, MULHSU and MULHU take [63:32].
- DONE: mul_finish=1 for exactly this cycle; next state is IDLE unconditionally.
- Latency: start sampled at edge T gives mul_finish high in cycle T+33 (T+1 with zero skip).
- Back-to-back multiplies: the pipeline advances during the DONE cycle, IDLE re-samples mul_start at T+34, and the new operands are captured there. There is no double-capture of the same instruction.
- Flush:
  - In BUSY, flush sends the next state to IDLE with no mul_finish; mul_result is unchanged.
  - In DONE, flush has no effect (the pulse has already been issued).
- Operands and op are ignored after capture; they may change during BUSY.
- mul_busy is combinational from state; mul_finish and mul_result are registered.

Decomposition:
Shared package mul_pkg:
- mul_op_t enum: MUL_LO, MUL_HSS, MUL_HSU, MUL_HUU
- mul_state_t enum: IDLE, BUSY, DONE
- MUL_ITER = XLEN

One sub-module, mul_shift_add:
- Holds the accumulator, multiplicand and multiplier registers and the count.
- Ports: load, step, last.
- mul_seq_ctrl keeps the FSM, sign handling, half select and result register.

Test Plan:
1. MUL 7 × 0xFFFFFFFD (−3), start at T -> mul_busy high from T+1; mul_finish a single pulse at T+33; mul_result=0xFFFFFFEB.
2. MULH 0x80000000 × 0x80000000 -> mul_result=0x40000000. MULHU with the same operands -> 0x40000000. MUL with the same operands -> 0x00000000.
3. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> mul_result=0xFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFE.
4. Zero skip: MUL 0 × 0x1234 -> mul_finish at T+1, result 0. Repeat with ZERO_SKIP=0 -> finish at T+33, result 0.
5. Flush at T+10 during BUSY -> IDLE at T+11, no finish pulse, mul_result keeps its old value. A new start at T+11 completes at T+44.
6. rst=0 at T+5 -> next cycle busy=0, finish=0, result=0. Two back-to-back MULs (2×3, then 4×5 captured at T+34) -> pulses at T+33 and T+67, results 6 and 20.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared types and constants for the RV32M iterative multiplier.
package mul_pkg;

  localparam int MUL_XLEN = 32;
  localparam int MUL_ITER = MUL_XLEN;

  // Encoding matches the funct3[1:0] ordering of MUL/MULH/MULHSU/MULHU.
  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MUL_HSS = 2'b01,
    MUL_HSU = 2'b10,
    MUL_HUU = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_shift_add.sv
// mul_shift_add: unsigned shift-add datapath, one multiplier bit per step.
// The multiplier lives in the low half of the accumulator and is shifted
// out as product bits are shifted in, so no separate multiplier register
// is needed once loading is done.
module mul_shift_add
  import mul_pkg::*;
#(
  parameter int XLEN = MUL_XLEN,
  parameter int ITER = MUL_ITER
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                step_i,
  input  logic [XLEN-1:0]     mcand_i,
  input  logic [XLEN-1:0]     mplier_i,
  output logic                last_o,
  output logic [2*XLEN-1:0]   prod_o
);

  localparam int CW = $clog2(ITER);

  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] accHi_q;
  logic [XLEN-1:0] accLo_q;
  logic [XLEN:0]   sum;

  // Conditional add of the multiplicand into the upper half, carry kept.
  always_comb begin
    sum = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
  end

  // Product as it will look after the current step's shift; the controller
  // samples this on the final step so no extra settle cycle is needed.
  assign prod_o = {sum, accLo_q[XLEN-1:1]};
  assign last_o = (count_q == CW'(ITER - 1));

  // Load operands, then add-and-shift once per step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      mcand_q <= '0;
      accHi_q <= '0;
      accLo_q <= '0;
    end else if (load_i) begin
      count_q <= '0;
      mcand_q <= mcand_i;
      accHi_q <= '0;
      accLo_q <= mplier_i;
    end else if (step_i) begin
      count_q <= count_q + CW'(1);
      accHi_q <= sum[XLEN:1];
      accLo_q <= {sum[0], accLo_q[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: EX-stage sequencer for RV32M MUL/MULH/MULHSU/MULHU.
// Multiplies magnitudes with mul_shift_add, then restores the sign and
// picks the requested half of the 2*XLEN product.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int XLEN      = MUL_XLEN,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mul_start,
  input  logic [1:0]      mul_op,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            mul_busy,
  output logic            mul_finish,
  output logic [XLEN-1:0] mul_result
);

  mul_state_t        state_q, state_d;
  mul_op_t           op_q;
  logic              sign_q;
  logic [XLEN-1:0]   result_q;
  logic              finish_q;

  mul_op_t           opIn;
  logic              rs1Neg, rs2Neg, zeroOp;
  logic              capture, skip, load, step, last;
  logic [XLEN-1:0]   rs1Mag, rs2Mag, resultSel;
  logic [2*XLEN-1:0] stepProd, prodSigned;

  // Decode signedness from the op and reduce both operands to magnitudes.
  always_comb begin
    opIn   = mul_op_t'(mul_op);
    rs1Neg = (opIn != MUL_HUU) && rs1_data[XLEN-1];
    rs2Neg = ((opIn == MUL_LO) || (opIn == MUL_HSS)) && rs2_data[XLEN-1];
    rs1Mag = rs1Neg ? -rs1_data : rs1_data;
    rs2Mag = rs2Neg ? -rs2_data : rs2_data;
    zeroOp = (rs1_data == '0) || (rs2_data == '0);
  end

  // Accept a new multiply only from IDLE; a killed instruction is ignored.
  always_comb begin
    capture = (state_q == IDLE) && mul_start && !flush;
    skip    = capture && ZERO_SKIP && zeroOp;
    load    = capture && !skip;
    step    = (state_q == BUSY) && !flush;
  end

  mul_shift_add #(
    .XLEN (XLEN),
    .ITER (XLEN)
  ) u_shift_add (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .step_i   (step),
    .mcand_i  (rs1Mag),
    .mplier_i (rs2Mag),
    .last_o   (last),
    .prod_o   (stepProd)
  );

  // Restore the sign of the full product, then select the requested half.
  always_comb begin
    prodSigned = sign_q ? -stepProd : stepProd;
    resultSel  = (op_q == MUL_LO) ? prodSigned[XLEN-1:0] : prodSigned[2*XLEN-1:XLEN];
  end

  // Next-state logic: DONE always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (capture) state_d = skip ? DONE : BUSY;
      BUSY: begin
        if (flush)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, captured op/sign, registered finish pulse and result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= MUL_LO;
      sign_q   <= 1'b0;
      result_q <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      finish_q <= (state_d == DONE);
      if (capture) begin
        op_q   <= opIn;
        sign_q <= rs1Neg ^ rs2Neg;
      end
      if (skip) begin
        result_q <= '0;
      end else if (step && last) begin
        result_q <= resultSel;
      end
    end
  end

  assign mul_busy   = (state_q != IDLE);
  assign mul_finish = finish_q;
  assign mul_result = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: table vectors, hand sequences for flush/reset/back-to-back,
// and random operations checked against a 64-bit arithmetic reference.
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        mul_start;
  logic [1:0]  mul_op;
  logic        flush;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        busyA, finishA, busyB, finishB;
  logic [31:0] resultA, resultB;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    string       name;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] prevExp;

  // Zero-skip instance
  mul_seq_ctrl #(.XLEN(32), .ZERO_SKIP(1'b1)) dutA (
    .clk(clk), .rst(rst), .mul_start(mul_start), .mul_op(mul_op), .flush(flush),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .mul_busy(busyA), .mul_finish(finishA), .mul_result(resultA)
  );

  // Always-iterate instance
  mul_seq_ctrl #(.XLEN(32), .ZERO_SKIP(1'b0)) dutB (
    .clk(clk), .rst(rst), .mul_start(mul_start), .mul_op(mul_op), .flush(flush),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .mul_busy(busyB), .mul_finish(finishB), .mul_result(resultB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case the DUT never lets the bench reach its summary.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] timeout");
  end

  // Reference: sign/zero extend to 64 bits and multiply.
  function automatic logic [31:0] refMul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op != 2'b11) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = ((op == 2'b00) || (op == 2'b01)) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Samples both DUTs #1 after each of n consecutive edges (first sample is
  // taken immediately) and reports pulse counts and first pulse index.
  task automatic watchCycles(input int n, output int pulsesA, output int firstA,
                             output int pulsesB, output int firstB);
    pulsesA = 0; firstA = -1; pulsesB = 0; firstB = -1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (finishA) begin
        if (pulsesA == 0) firstA = k;
        pulsesA++;
      end
      if (finishB) begin
        if (pulsesB == 0) firstB = k;
        pulsesB++;
      end
    end
  endtask

  // One full multiply; operands are scrambled right after capture.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes, input string tag);
    int pA, fA, pB, fB, expFirstA;
    expFirstA = ((a == 32'h0) || (b == 32'h0)) ? 0 : 32;
    @(negedge clk);
    mul_op = op; rs1_data = a; rs2_data = b; mul_start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, " busyA"}, 32'(busyA), 32'd1);
    checkOutput({tag, " busyB"}, 32'(busyB), 32'd1);
    mul_start = 1'b0;
    mul_op    = 2'($urandom_range(0, 3));
    rs1_data  = $urandom;
    rs2_data  = $urandom;
    watchCycles(40, pA, fA, pB, fB);
    checkOutput({tag, " pulsesA"}, 32'(pA), 32'd1);
    checkOutput({tag, " latA"},    32'(fA), 32'(expFirstA));
    checkOutput({tag, " pulsesB"}, 32'(pB), 32'd1);
    checkOutput({tag, " latB"},    32'(fB), 32'd32);
    checkOutput({tag, " resA"},    resultA, expRes);
    checkOutput({tag, " resB"},    resultB, expRes);
  endtask

  initial begin
    int pA, fA, pB, fB;
    int nA, nB;
    int idxA[2], idxB[2];
    logic [31:0] resA[2], resB[2];
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{2'b00, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul 7x-3"};
    vecs[1] = '{2'b01, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh min^2"};
    vecs[2] = '{2'b11, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulhu 2^31^2"};
    vecs[3] = '{2'b00, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, "mul min^2"};
    vecs[4] = '{2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu -1xmax"};
    vecs[5] = '{2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu max^2"};
    vecs[6] = '{2'b00, 32'h0,          32'h1234,      32'h0000_0000, "mul zero"};
    vecs[7] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, "mulh -1x-1"};
    vecs[8] = '{2'b01, 32'h7FFF_FFFF,  32'h8000_0000, 32'hC000_0000, "mulh max x min"};

    rst = 1'b0; mul_start = 1'b0; mul_op = 2'b00; flush = 1'b0;
    rs1_data = 32'h0; rs2_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busyA",   32'(busyA),   32'd0);
    checkOutput("reset finishA", 32'(finishA), 32'd0);
    checkOutput("reset resultA", resultA,      32'd0);
    checkOutput("reset busyB",   32'(busyB),   32'd0);
    checkOutput("reset finishB", 32'(finishB), 32'd0);
    checkOutput("reset resultB", resultB,      32'd0);
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].name);
    end
    prevExp = vecs[8].res;

    // A killed instruction in IDLE must not start anything
    @(negedge clk);
    mul_op = 2'b00; rs1_data = 32'd5; rs2_data = 32'd6; mul_start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle flush busyA", 32'(busyA), 32'd0);
    checkOutput("idle flush busyB", 32'(busyB), 32'd0);
    mul_start = 1'b0; flush = 1'b0;

    // Flush during BUSY aborts without a pulse and keeps the old result
    @(negedge clk);
    mul_op = 2'b11; rs1_data = 32'd3; rs2_data = 32'd5; mul_start = 1'b1;
    @(posedge clk);
    #1;
    mul_start = 1'b0;
    watchCycles(10, pA, fA, pB, fB);
    checkOutput("flush early pulsesA", 32'(pA), 32'd0);
    checkOutput("flush early pulsesB", 32'(pB), 32'd0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush busyA",   32'(busyA),   32'd0);
    checkOutput("flush finishA", 32'(finishA), 32'd0);
    checkOutput("flush resultA", resultA,      prevExp);
    checkOutput("flush busyB",   32'(busyB),   32'd0);
    checkOutput("flush resultB", resultB,      prevExp);
    applyStimulus(2'b00, 32'd9, 32'd11, 32'd99, "after flush");

    // Reset mid-operation aborts and clears the result
    @(negedge clk);
    mul_op = 2'b00; rs1_data = 32'd123; rs2_data = 32'd456; mul_start = 1'b1;
    @(posedge clk);
    #1;
    mul_start = 1'b0;
    watchCycles(5, pA, fA, pB, fB);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checkOutput("midrst busyA",   32'(busyA),   32'd0);
    checkOutput("midrst finishA", 32'(finishA), 32'd0);
    checkOutput("midrst resultA", resultA,      32'd0);
    checkOutput("midrst busyB",   32'(busyB),   32'd0);
    checkOutput("midrst resultB", resultB,      32'd0);
    watchCycles(40, pA, fA, pB, fB);
    checkOutput("midrst pulsesA", 32'(pA), 32'd0);
    checkOutput("midrst pulsesB", 32'(pB), 32'd0);

    // Back-to-back: start held high, next instruction appears after DONE
    @(negedge clk);
    mul_op = 2'b00; rs1_data = 32'd2; rs2_data = 32'd3; mul_start = 1'b1;
    @(posedge clk);
    nA = 0; nB = 0;
    idxA = '{-1, -1}; idxB = '{-1, -1};
    resA = '{32'h0, 32'h0}; resB = '{32'h0, 32'h0};
    for (int k = 0; k < 72; k++) begin
      #1;
      if (finishA) begin
        if (nA < 2) begin idxA[nA] = k; resA[nA] = resultA; end
        nA++;
      end
      if (finishB) begin
        if (nB < 2) begin idxB[nB] = k; resB[nB] = resultB; end
        nB++;
      end
      if (k == 33) begin rs1_data = 32'd4; rs2_data = 32'd5; end
      if (k == 67) mul_start = 1'b0;
      @(posedge clk);
    end
    checkOutput("b2b pulsesA", 32'(nA),     32'd2);
    checkOutput("b2b lat1A",   32'(idxA[0]), 32'd32);
    checkOutput("b2b res1A",   resA[0],      32'd6);
    checkOutput("b2b lat2A",   32'(idxA[1]), 32'd66);
    checkOutput("b2b res2A",   resA[1],      32'd20);
    checkOutput("b2b pulsesB", 32'(nB),     32'd2);
    checkOutput("b2b lat2B",   32'(idxB[1]), 32'd66);
    checkOutput("b2b res2B",   resB[1],      32'd20);

    // Random operations against the arithmetic reference
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pickOperand();
      rb  = pickOperand();
      applyStimulus(rop, ra, rb, refMul(rop, ra, rb), $sformatf("rnd%0d op%0d", i, rop));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
